// File: rtl/jt900h_eacalc.sv
// jt900h_eacalc - effective-address calculator for TLCS-900H memory operands.
//
// Decodes the addressing byte(s) in the fetch window, drives the register-bank
// read selects, adds base + offset (or base - step for pre-decrement) modulo
// 2^AW, and presents the result on a valid/ack handshake.
//
// Ports
//   clk, rst, cen       clock, async active-high reset, clock enable
//   op, op_valid        fetch window (op[7:0] = mode byte) and request strobe
//   fetched             bytes consumed, pulsed for one cen cycle after decode
//   rdreg_sel, rdreg    base register select / value (read during RD)
//   rdaux_sel, rdaux    offset register select / value (r32+r8/r16 only)
//   reg_step            step size code (0=1, 1=2, 2=4 bytes)
//   reg_inc, reg_dec    one-cen pulses to update the base register on accept
//   ea_valid, ea_ack, ea  result handshake
//   err                 one-cen pulse for an unsupported mode byte
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for op_valid; decode the mode byte and latch selects
// RD    | register bank output valid; form ea
// DONE  | ea_valid high until ea_ack (or abort when op_valid drops)
module jt900h_eacalc #(
    parameter int         AW      = 24,
    parameter logic [7:0] NULLREG = 8'h40,
    parameter logic [7:0] XBASE   = 8'he0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic [31:0]   op,
    input  logic          op_valid,
    output logic [2:0]    fetched,
    output logic [7:0]    rdreg_sel,
    input  logic [31:0]   rdreg,
    output logic [7:0]    rdaux_sel,
    input  logic [15:0]   rdaux,
    output logic [1:0]    reg_step,
    output logic          reg_inc,
    output logic          reg_dec,
    output logic          ea_valid,
    input  logic          ea_ack,
    output logic [AW-1:0] ea,
    output logic          err
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    fetched_q, fetched_d;
    logic [7:0]    rdreg_sel_q, rdreg_sel_d;
    logic [7:0]    rdaux_sel_q, rdaux_sel_d;
    logic [1:0]    reg_step_q, reg_step_d;
    logic          reg_inc_q, reg_inc_d;
    logic          reg_dec_q, reg_dec_d;
    logic          ea_valid_q, ea_valid_d;
    logic [AW-1:0] ea_q, ea_d;
    logic          err_q, err_d;
    logic [AW-1:0] off_q, off_d;
    logic          use_aux_q, use_aux_d;
    logic          aux_wide_q, aux_wide_d;
    logic          inc_mode_q, inc_mode_d;
    logic          dec_mode_q, dec_mode_d;

    // Combinational decode of the current fetch window
    logic          dec_ok;
    logic [2:0]    dec_len;
    logic [7:0]    dec_base;
    logic [7:0]    dec_aux;
    logic [AW-1:0] dec_off;
    logic [1:0]    dec_step;
    logic          dec_use_aux;
    logic          dec_inc;
    logic          dec_dec;
    logic [7:0]    r32_base;
    logic [AW-1:0] rd_off;

    // Mode byte bits 7 and 5:4 do not take part in operand decoding
    logic unused_bits;
    assign unused_bits = &{1'b0, op[7], op[5:4], rdreg};

    assign r32_base = {op[15:10], 2'b00};

    always_comb begin
        dec_ok      = 1'b1;
        dec_len     = 3'd1;
        dec_base    = NULLREG;
        dec_aux     = NULLREG;
        dec_off     = '0;
        dec_step    = 2'd0;
        dec_use_aux = 1'b0;
        dec_inc     = 1'b0;
        dec_dec     = 1'b0;
        if (!op[6]) begin
            dec_base = XBASE + {3'b000, op[2:0], 2'b00};
            if (op[3]) begin
                dec_off = AW'($signed(op[15:8]));
                dec_len = 3'd2;
            end
        end else begin
            case (op[3:0])
                4'h0: begin dec_off = AW'(op[15:8]); dec_len = 3'd2; end
                4'h1: begin dec_off = AW'(op[23:8]); dec_len = 3'd3; end
                4'h2: begin dec_off = AW'(op[31:8]); dec_len = 3'd4; end
                4'h3: begin
                    case (op[9:8])
                        2'd0: begin dec_base = r32_base; dec_len = 3'd2; end
                        2'd1: begin
                            dec_base = r32_base;
                            dec_off  = AW'($signed(op[31:16]));
                            dec_len  = 3'd4;
                        end
                        2'd3: begin
                            dec_base    = op[23:16];
                            dec_aux     = op[31:24];
                            dec_use_aux = 1'b1;
                            dec_len     = 3'd4;
                        end
                        default: dec_ok = 1'b0;
                    endcase
                end
                4'h4, 4'h5: begin
                    dec_base = r32_base;
                    dec_step = op[9:8];
                    dec_len  = 3'd2;
                    dec_ok   = (op[9:8] != 2'd3);
                    dec_dec  = ~op[0];
                    dec_inc  = op[0];
                    // pre-decrement folds into the common add as a negative offset
                    if (!op[0]) dec_off = -(AW'(1) << op[9:8]);
                end
                default: dec_ok = 1'b0;
            endcase
        end
    end

    // The aux register is only readable in RD, so its extension happens there
    assign rd_off = !use_aux_q ? off_q :
                    aux_wide_q ? AW'($signed(rdaux)) : AW'($signed(rdaux[7:0]));

    always_comb begin
        state_d     = state_q;
        fetched_d   = 3'd0;
        rdreg_sel_d = rdreg_sel_q;
        rdaux_sel_d = rdaux_sel_q;
        reg_step_d  = reg_step_q;
        reg_inc_d   = 1'b0;
        reg_dec_d   = 1'b0;
        ea_valid_d  = ea_valid_q;
        ea_d        = ea_q;
        err_d       = 1'b0;
        off_d       = off_q;
        use_aux_d   = use_aux_q;
        aux_wide_d  = aux_wide_q;
        inc_mode_d  = inc_mode_q;
        dec_mode_d  = dec_mode_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    if (dec_ok) begin
                        fetched_d   = dec_len;
                        rdreg_sel_d = dec_base;
                        rdaux_sel_d = dec_aux;
                        reg_step_d  = dec_step;
                        off_d       = dec_off;
                        use_aux_d   = dec_use_aux;
                        aux_wide_d  = op[10];
                        inc_mode_d  = dec_inc;
                        dec_mode_d  = dec_dec;
                        state_d     = S_RD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RD: begin
                if (!op_valid) begin
                    state_d = S_IDLE;
                end else begin
                    ea_d       = rdreg[AW-1:0] + rd_off;
                    ea_valid_d = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                // an abort wins over a simultaneous ack: no register update
                if (!op_valid) begin
                    ea_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (ea_ack) begin
                    ea_valid_d = 1'b0;
                    reg_inc_d  = inc_mode_q;
                    reg_dec_d  = dec_mode_q;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                ea_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fetched_q   <= 3'd0;
            rdreg_sel_q <= NULLREG;
            rdaux_sel_q <= NULLREG;
            reg_step_q  <= 2'd0;
            reg_inc_q   <= 1'b0;
            reg_dec_q   <= 1'b0;
            ea_valid_q  <= 1'b0;
            ea_q        <= '0;
            err_q       <= 1'b0;
            off_q       <= '0;
            use_aux_q   <= 1'b0;
            aux_wide_q  <= 1'b0;
            inc_mode_q  <= 1'b0;
            dec_mode_q  <= 1'b0;
        end else if (cen) begin
            state_q     <= state_d;
            fetched_q   <= fetched_d;
            rdreg_sel_q <= rdreg_sel_d;
            rdaux_sel_q <= rdaux_sel_d;
            reg_step_q  <= reg_step_d;
            reg_inc_q   <= reg_inc_d;
            reg_dec_q   <= reg_dec_d;
            ea_valid_q  <= ea_valid_d;
            ea_q        <= ea_d;
            err_q       <= err_d;
            off_q       <= off_d;
            use_aux_q   <= use_aux_d;
            aux_wide_q  <= aux_wide_d;
            inc_mode_q  <= inc_mode_d;
            dec_mode_q  <= dec_mode_d;
        end
    end

    assign fetched   = fetched_q;
    assign rdreg_sel = rdreg_sel_q;
    assign rdaux_sel = rdaux_sel_q;
    assign reg_step  = reg_step_q;
    assign reg_inc   = reg_inc_q;
    assign reg_dec   = reg_dec_q;
    assign ea_valid  = ea_valid_q;
    assign ea        = ea_q;
    assign err       = err_q;

endmodule

// File: tb/tb_jt900h_eacalc.sv
// tb_jt900h_eacalc - bench for the effective-address calculator. A register
// bank is modelled as a plain array; expected addresses come from a mode-level
// reference model using integer arithmetic modulo 2^24.
module tb_jt900h_eacalc;

    logic        clk;
    logic        rst;
    logic        cen;
    logic [31:0] op;
    logic        op_valid;
    logic [2:0]  fetched;
    logic [7:0]  rdreg_sel;
    logic [31:0] rdreg;
    logic [7:0]  rdaux_sel;
    logic [15:0] rdaux;
    logic [1:0]  reg_step;
    logic        reg_inc;
    logic        reg_dec;
    logic        ea_valid;
    logic        ea_ack;
    logic [23:0] ea;
    logic        err;

    int vectors;
    int miscompares;

    logic [31:0] regs [256];

    jt900h_eacalc dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .op        (op),
        .op_valid  (op_valid),
        .fetched   (fetched),
        .rdreg_sel (rdreg_sel),
        .rdreg     (rdreg),
        .rdaux_sel (rdaux_sel),
        .rdaux     (rdaux),
        .reg_step  (reg_step),
        .reg_inc   (reg_inc),
        .reg_dec   (reg_dec),
        .ea_valid  (ea_valid),
        .ea_ack    (ea_ack),
        .ea        (ea),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank: select 0x40 reads as zero
    assign rdreg = (rdreg_sel == 8'h40) ? 32'h0 : regs[rdreg_sel];
    assign rdaux = (rdaux_sel == 8'h40) ? 16'h0 : regs[rdaux_sel][15:0];

    typedef struct {
        bit       ok;
        int       len;
        bit [7:0] bsel;
        bit [7:0] asel;
        bit [1:0] step;
        longint   off;
        bit       aux;
        bit       wide;
        bit       inc;
        bit       dec;
    } exp_t;

    function automatic exp_t model(input logic [31:0] o);
        exp_t e;
        int   key;
        e.ok = 1; e.len = 1; e.bsel = 8'h40; e.asel = 8'h40; e.step = 0;
        e.off = 0; e.aux = 0; e.wide = o[10]; e.inc = 0; e.dec = 0;
        key = {27'd0, o[6], o[3:0]};
        if (key < 16) begin
            e.bsel = 8'(224 + 4 * int'(o[2:0]));          // XWA + 4*r
            if (key >= 8) begin
                e.off = longint'($signed(o[15:8]));
                e.len = 2;
            end
        end else if (key == 16) begin
            e.off = longint'(o[15:8]);  e.len = 2;
        end else if (key == 17) begin
            e.off = longint'(o[23:8]);  e.len = 3;
        end else if (key == 18) begin
            e.off = longint'(o[31:8]);  e.len = 4;
        end else if (key == 19) begin
            if (o[9:8] == 0) begin
                e.bsel = 8'(int'(o[15:10]) * 4); e.len = 2;
            end else if (o[9:8] == 1) begin
                e.bsel = 8'(int'(o[15:10]) * 4); e.len = 4;
                e.off  = longint'($signed(o[31:16]));
            end else if (o[9:8] == 3) begin
                e.bsel = o[23:16]; e.asel = o[31:24]; e.aux = 1; e.len = 4;
            end else begin
                e.ok = 0;
            end
        end else if (key == 20 || key == 21) begin
            if (o[9:8] == 3) begin
                e.ok = 0;
            end else begin
                e.bsel = 8'(int'(o[15:10]) * 4);
                e.step = o[9:8];
                e.len  = 2;
                if (key == 20) begin
                    e.dec = 1;
                    e.off = -(longint'(1) << o[9:8]);
                end else begin
                    e.inc = 1;
                end
            end
        end else begin
            e.ok = 0;
        end
        return e;
    endfunction

    function automatic logic [23:0] model_ea(input exp_t e);
        longint     sum;
        logic [31:0] b;
        logic [15:0] a;
        b   = (e.bsel == 8'h40) ? 32'h0 : regs[e.bsel];
        a   = (e.asel == 8'h40) ? 16'h0 : regs[e.asel][15:0];
        sum = longint'(b[23:0]) + e.off;
        if (e.aux) sum = sum + (e.wide ? longint'($signed(a)) : longint'($signed(a[7:0])));
        return sum[23:0];
    endfunction

    // Runs one request from a negedge; returns at a negedge. keep leaves
    // op_valid high so the caller can present the next op back to back.
    task automatic run_op(input logic [31:0] o, input int hold, input bit keep,
                          input bit chk_want, input logic [23:0] want);
        exp_t        e;
        logic [23:0] exp_ea;
        logic [25:0] got_d, exp_d;
        e      = model(o);
        exp_ea = model_ea(e);
        op = o; op_valid = 1'b1; ea_ack = 1'b0;
        @(negedge clk);
        if (!e.ok) begin
            vectors++;
            if ({err, fetched} !== {1'b1, 3'd0}) begin
                miscompares++;
                $display("FAIL bad_mode op=%h: err,fetched got %b,%0d want 1,0", o, err, fetched);
            end
            op_valid = 1'b0;
            @(negedge clk);
            vectors++;
            if (err !== 1'b0) begin
                miscompares++;
                $display("FAIL err_pulse op=%h: err got %b want 0", o, err);
            end
            return;
        end
        got_d = {fetched, rdreg_sel, rdaux_sel, reg_step, err, ea_valid, reg_inc, reg_dec};
        exp_d = {3'(e.len), e.bsel, e.asel, e.step, 4'b0000};
        vectors++;
        if (got_d !== exp_d) begin
            miscompares++;
            $display("FAIL decode op=%h: {fetched,sel,aux,step,err,v,inc,dec} got %h want %h",
                     o, got_d, exp_d);
        end
        @(negedge clk);
        vectors++;
        if ({ea_valid, ea, fetched} !== {1'b1, exp_ea, 3'd0}) begin
            miscompares++;
            $display("FAIL ea op=%h: valid,ea,fetched got %b,%h,%0d want 1,%h,0",
                     o, ea_valid, ea, fetched, exp_ea);
        end
        if (chk_want) begin
            vectors++;
            if (ea !== want) begin
                miscompares++;
                $display("FAIL ea_const op=%h: ea got %h want %h", o, ea, want);
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            vectors++;
            if ({ea_valid, ea, reg_inc, reg_dec} !== {1'b1, exp_ea, 2'b00}) begin
                miscompares++;
                $display("FAIL hold op=%h: valid,ea,inc,dec got %b,%h,%b%b want 1,%h,00",
                         o, ea_valid, ea, reg_inc, reg_dec, exp_ea);
            end
        end
        ea_ack = 1'b1;
        @(negedge clk);
        ea_ack = 1'b0;
        vectors++;
        if ({ea_valid, reg_inc, reg_dec} !== {1'b0, e.inc, e.dec}) begin
            miscompares++;
            $display("FAIL accept op=%h: valid,inc,dec got %b,%b%b want 0,%b%b",
                     o, ea_valid, reg_inc, reg_dec, e.inc, e.dec);
        end
        if (!keep) begin
            op_valid = 1'b0;
            @(negedge clk);
            vectors++;
            if ({ea_valid, reg_inc, reg_dec, fetched} !== 6'd0) begin
                miscompares++;
                $display("FAIL after op=%h: valid,inc,dec,fetched got %b,%b%b,%0d want 0,00,0",
                         o, ea_valid, reg_inc, reg_dec, fetched);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [47:0] got_r, exp_r;
        got_r = {fetched, rdreg_sel, rdaux_sel, reg_step, reg_inc, reg_dec, ea_valid, ea, err};
        exp_r = {3'd0, 8'h40, 8'h40, 2'd0, 3'b000, 24'd0, 1'b0};
        vectors++;
        if (got_r !== exp_r) begin
            miscompares++;
            $display("FAIL %s: outputs got %h want %h", tag, got_r, exp_r);
        end
    endtask

    task automatic test_reset();
        check_reset_outputs("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_released");
    endtask

    task automatic test_directed();
        regs[8'hec] = 32'h0012_3456;
        run_op(32'h0000_0003, 0, 0, 1, 24'h123456);       // XHL
        regs[8'he4] = 32'h0000_1000;
        run_op(32'h0000_8089, 1, 0, 1, 24'h000F80);       // XBC + d8 (-0x80)
        run_op(32'h5634_12F2, 0, 0, 1, 24'h563412);       // n24
        regs[8'he8] = 32'h0000_8000;
        regs[8'h30] = 32'h0000_FFF0;
        run_op(32'h30E8_07C3, 0, 0, 1, 24'h007FF0);       // XDE + r16
        regs[8'h30] = 32'h0000_0010;
        run_op(32'h30E8_03C3, 0, 0, 1, 24'h008010);       // XDE + r8
        regs[8'he8] = 32'h00FF_FFFF;
        run_op(32'h0001_E9C3, 0, 0, 1, 24'h000000);       // r32+d16 carry wrap
    endtask

    task automatic test_predec();
        regs[8'hf4] = 32'h0000_0002;
        run_op(32'h0000_F6C4, 3, 0, 1, 24'hFFFFFE);       // -XIY, step 4
    endtask

    task automatic test_bad_mode();
        run_op(32'h0000_00C7, 0, 0, 0, 24'h0);            // key 1_0111
        run_op(32'h0000_0046, 0, 0, 0, 24'h0);            // key 1_0110
        run_op(32'h0000_02C3, 0, 0, 0, 24'h0);            // r32 sub-mode 2
        run_op(32'h0000_E3C5, 0, 0, 0, 24'h0);            // step code 3
    endtask

    task automatic test_abort();
        regs[8'he0] = 32'h00AB_CDEF;
        op = 32'h0000_E1C5; op_valid = 1'b1;              // XWA+, step 2
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (ea_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_setup: ea_valid got %b want 1", ea_valid);
        end
        op_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if ({ea_valid, reg_inc} !== 2'b00) begin
                miscompares++;
                $display("FAIL abort_done: valid,inc got %b%b want 00", ea_valid, reg_inc);
            end
        end
        op_valid = 1'b1;
        ea_ack = 1'b1;                                    // ignored outside DONE
        @(negedge clk);
        op_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if ({ea_valid, reg_inc} !== 2'b00) begin
                miscompares++;
                $display("FAIL abort_rd: valid,inc got %b%b want 00", ea_valid, reg_inc);
            end
        end
        ea_ack = 1'b0;
    endtask

    task automatic test_cen_freeze();
        regs[8'he0] = 32'h00AB_CDEF;
        op = 32'h0000_E1C5; op_valid = 1'b1; cen = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({fetched, ea_valid} !== 4'd0) begin
            miscompares++;
            $display("FAIL cen_idle: fetched,valid got %0d,%b want 0,0", fetched, ea_valid);
        end
        cen = 1'b1;
        @(negedge clk);
        cen = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({fetched, reg_step, ea_valid} !== {3'd2, 2'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL cen_fetch_stretch: fetched,step,valid got %0d,%0d,%b want 2,1,0",
                     fetched, reg_step, ea_valid);
        end
        cen = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ea_valid, ea} !== {1'b1, 24'hABCDEF}) begin
            miscompares++;
            $display("FAIL cen_ea: valid,ea got %b,%h want 1,abcdef", ea_valid, ea);
        end
        ea_ack = 1'b1; cen = 1'b0;
        @(negedge clk);
        vectors++;
        if ({ea_valid, reg_inc} !== 2'b10) begin
            miscompares++;
            $display("FAIL cen_ack_frozen: valid,inc got %b%b want 10", ea_valid, reg_inc);
        end
        cen = 1'b1;
        @(negedge clk);
        ea_ack = 1'b0; op_valid = 1'b0; cen = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({ea_valid, reg_inc, reg_dec} !== 3'b010) begin
            miscompares++;
            $display("FAIL cen_inc_stretch: valid,inc,dec got %b%b%b want 010",
                     ea_valid, reg_inc, reg_dec);
        end
        cen = 1'b1;
        @(negedge clk);
        vectors++;
        if (reg_inc !== 1'b0) begin
            miscompares++;
            $display("FAIL cen_inc_end: inc got %b want 0", reg_inc);
        end
    endtask

    task automatic test_async_reset();
        regs[8'he0] = 32'h0000_0100;
        op = 32'h0000_E1C5; op_valid = 1'b1;
        repeat (2) @(negedge clk);
        ea_ack = 1'b1;
        @(negedge clk);
        ea_ack = 1'b0;
        vectors++;
        if (reg_inc !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_setup: inc got %b want 1", reg_inc);
        end
        #1 rst = 1'b1;
        #1 check_reset_outputs("async_reset_pulse_lost");
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("async_reset_released");
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            run_op($urandom(), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, 24'h0);
        end
        op_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1; op = '0; op_valid = 1'b0; ea_ack = 1'b0;
        vectors = 0; miscompares = 0;
        for (int i = 0; i < 256; i++) regs[i] = $urandom();
        repeat (2) @(negedge clk);
        test_reset();
        test_directed();
        test_predec();
        test_bad_mode();
        test_abort();
        test_cen_freeze();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
